// File: rtl/fpall_sched.sv
// fpall_pkg: opcode and format encodings shared by requesters, scheduler and fpall_shared.
package fpall_pkg;
  typedef enum logic [1:0] {OP_ADD = 2'd0, OP_MUL = 2'd1, OP_SQRT = 2'd2} opcode_e;
  typedef enum logic {FP32 = 1'b0, FP16 = 1'b1} fmt_e;
endpackage

// fpall_sched: round-robin front end for one shared FP unit. Grants at most one
// requester per cycle, registers the winning operation onto the unit, tracks it
// in flight and routes the unit's result back to its owner as a one-cycle pulse.
// SQRT blocks further issue until its result has been captured, so completions
// can never collide and always return in issue order.
module fpall_sched
  import fpall_pkg::*;
#(
  parameter int N_REQ    = 2,
  parameter int LATENCY  = 1,
  parameter int SQRT_LAT = 4
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic    [N_REQ-1:0]         i_req_valid,
  output logic    [N_REQ-1:0]         o_req_ready,
  input  opcode_e [N_REQ-1:0]         i_req_opcode,
  input  fmt_e    [N_REQ-1:0]         i_req_fmt,
  input  logic    [N_REQ-1:0][31:0]   i_req_x,
  input  logic    [N_REQ-1:0][31:0]   i_req_y,
  output opcode_e                     o_fpu_opcode,
  output fmt_e                        o_fpu_fmt,
  output logic    [31:0]              o_fpu_x,
  output logic    [31:0]              o_fpu_y,
  input  logic    [31:0]              i_fpu_r,
  output logic    [N_REQ-1:0]         o_rsp_valid,
  output logic    [31:0]              o_rsp_data
);

  localparam int IDW   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int DEPTH = (SQRT_LAT > LATENCY) ? SQRT_LAT : LATENCY;
  localparam int CW    = $clog2(SQRT_LAT + 1);

  typedef enum logic {RUN = 1'b0, SQRT_BUSY = 1'b1} state_e;

  // One in-flight slot: owner plus which tap it must leave the pipe at.
  typedef struct packed {
    logic           vld;
    logic           sqrt;
    logic [IDW-1:0] id;
  } trk_t;

  state_e         r_state, w_state_nx;
  logic [CW-1:0]  r_cnt;
  logic [IDW-1:0] r_ptr;          // requester holding top priority
  logic [N_REQ-1:0] w_ready;
  logic [IDW-1:0] w_gnt_id;
  logic [IDW-1:0] w_idx;
  logic           w_found;
  int             w_sum;
  logic           w_accept;
  logic           w_acc_sqrt;
  trk_t           r_iss;          // describes the op on o_fpu_* this cycle
  trk_t           r_trk [DEPTH];
  logic           w_hit_add;
  logic           w_hit_sqrt;
  logic [IDW-1:0] w_hit_id;

  // Round-robin pick: first valid requester scanning upward from r_ptr.
  always_comb begin
    w_ready  = '0;
    w_gnt_id = '0;
    w_found  = 1'b0;
    w_idx    = '0;
    w_sum    = 0;
    if (i_rst_n && r_state == RUN) begin
      for (int k = 0; k < N_REQ; k++) begin
        w_sum = int'(r_ptr) + k;
        if (w_sum >= N_REQ) w_sum = w_sum - N_REQ;
        w_idx = IDW'(w_sum);
        if (!w_found && i_req_valid[w_idx]) begin
          w_found         = 1'b1;
          w_ready[w_idx]  = 1'b1;
          w_gnt_id        = w_idx;
        end
      end
    end
  end

  assign o_req_ready = w_ready;
  assign w_accept    = w_found;
  assign w_acc_sqrt  = w_found && (i_req_opcode[w_gnt_id] == OP_SQRT);

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= RUN;
    else          r_state <= w_state_nx;
  end

  // Next state: a SQRT grant stalls issue; leave on the edge that captures its result.
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      RUN:       if (w_acc_sqrt) w_state_nx = SQRT_BUSY;
      SQRT_BUSY: if (r_cnt == '0) w_state_nx = RUN;
      default:   w_state_nx = RUN;
    endcase
  end

  // Stall counter: reaches zero exactly one cycle before the SQRT capture edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                             r_cnt <= '0;
    else if (w_acc_sqrt)                      r_cnt <= CW'(SQRT_LAT);
    else if (r_state == SQRT_BUSY && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
  end

  // Priority moves to the requester after the one just granted.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      r_ptr <= '0;
    else if (w_accept)
      r_ptr <= (w_gnt_id == IDW'(N_REQ - 1)) ? '0 : w_gnt_id + 1'b1;
  end

  // Issue register: drive the granted op for one cycle, hold the bus otherwise.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_fpu_opcode <= OP_ADD;
      o_fpu_fmt    <= FP32;
      o_fpu_x      <= '0;
      o_fpu_y      <= '0;
      r_iss        <= '0;
    end else if (w_accept) begin
      o_fpu_opcode <= i_req_opcode[w_gnt_id];
      o_fpu_fmt    <= i_req_fmt[w_gnt_id];
      o_fpu_x      <= i_req_x[w_gnt_id];
      o_fpu_y      <= i_req_y[w_gnt_id];
      r_iss        <= '{vld: 1'b1, sqrt: w_acc_sqrt, id: w_gnt_id};
    end else begin
      r_iss        <= '0;
    end
  end

  // In-flight pipe: slot k holds the op issued k+1 cycles ago.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < DEPTH; k++) r_trk[k] <= '0;
    end else begin
      r_trk[0] <= r_iss;
      for (int k = 1; k < DEPTH; k++) r_trk[k] <= r_trk[k-1];
    end
  end

  assign w_hit_add  = r_trk[LATENCY-1].vld  && !r_trk[LATENCY-1].sqrt;
  assign w_hit_sqrt = r_trk[SQRT_LAT-1].vld &&  r_trk[SQRT_LAT-1].sqrt;
  assign w_hit_id   = w_hit_sqrt ? r_trk[SQRT_LAT-1].id : r_trk[LATENCY-1].id;

  // Capture the unit result and pulse the owner's valid for one cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_rsp_valid <= '0;
      o_rsp_data  <= '0;
    end else begin
      o_rsp_valid <= '0;
      if (w_hit_add || w_hit_sqrt) begin
        o_rsp_valid[w_hit_id] <= 1'b1;
        o_rsp_data            <= i_fpu_r;
      end
    end
  end

endmodule
